// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor
//   Samples the 32-bit counter output on every enabled cycle and measures
//   switching activity as the Hamming distance between consecutive samples.
//   Distances are accumulated (saturating) over WINDOW compared samples and
//   each window total is offered on a valid/ready result port.
//
//   Optional feature macro: ACT_PEAK_EN
//     defined   -> act_peak reports the largest per-sample distance seen in
//                  the window, loaded together with act_count.
//     undefined -> act_peak port and the peak tracking logic are absent.
module toggle_activity_monitor #(
    parameter int WINDOW = 16,
    parameter int ACC_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      q_in,
    input  logic             sample_en,
    output logic [ACC_W-1:0] act_count,
    output logic             act_sat,
    output logic             act_valid,
    input  logic             act_ready,
    output logic             act_lost
`ifdef ACT_PEAK_EN
    ,
    output logic [5:0]       act_peak
`endif
);

    localparam int               CNT_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WINDOW - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    // IDLE waits for the first sample to prime r_prev; RUN compares.
    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [31:0]      r_prev;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_sat_win;

    logic [5:0]       w_hd;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_sat_next;
    logic             w_win_end;
    logic             w_accept;

`ifdef ACT_PEAK_EN
    logic [5:0]       r_peak;
    logic [5:0]       w_peak_next;
`endif

    // Distance of the current sample, saturating accumulate and window-end detect.
    always_comb begin
        // NOTE: every signal gets a value before any condition, so no latch is inferred.
        w_hd       = 6'($countones(q_in ^ r_prev));
        w_sum      = {1'b0, r_acc} + {{(ACC_W - 5){1'b0}}, w_hd};
        w_acc_next = w_sum[ACC_W] ? ACC_MAX : w_sum[ACC_W-1:0];
        w_sat_next = r_sat_win | w_sum[ACC_W];
        w_win_end  = (r_state == S_RUN) && sample_en && (r_wcnt == LAST);
        w_accept   = act_valid && act_ready;
`ifdef ACT_PEAK_EN
        w_peak_next = (w_hd > r_peak) ? w_hd : r_peak;
`endif
    end

    // Sampling FSM, window accumulation and the registered result handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge values of the others.
        if (reset) begin
            r_state   <= S_IDLE;
            r_prev    <= '0;
            r_acc     <= '0;
            r_wcnt    <= '0;
            r_sat_win <= 1'b0;
            act_count <= '0;
            act_sat   <= 1'b0;
            act_valid <= 1'b0;
            act_lost  <= 1'b0;
`ifdef ACT_PEAK_EN
            r_peak    <= '0;
            act_peak  <= '0;
`endif
        end else begin
            // An accepted result retires unless a new window end reloads it below.
            if (w_accept) begin
                act_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (sample_en) begin
                        r_prev  <= q_in;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (sample_en) begin
                        r_prev <= q_in;
                        if (w_win_end) begin
                            act_count <= w_acc_next;
                            act_sat   <= w_sat_next;
                            act_valid <= 1'b1;
                            // Pending result that nobody took is being replaced.
                            if (act_valid && !act_ready) begin
                                act_lost <= 1'b1;
                            end
                            r_acc     <= '0;
                            r_wcnt    <= '0;
                            r_sat_win <= 1'b0;
`ifdef ACT_PEAK_EN
                            act_peak  <= w_peak_next;
                            r_peak    <= '0;
`endif
                        end else begin
                            r_acc     <= w_acc_next;
                            r_wcnt    <= r_wcnt + 1'b1;
                            r_sat_win <= w_sat_next;
`ifdef ACT_PEAK_EN
                            r_peak    <= w_peak_next;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule
